// File: rtl/sauto_turn_ctrl.sv
// -----------------------------------------------------------------------------
// sauto_turn_ctrl
//
// Purpose:
//   Sequencer for a semi-automatic turn manoeuvre. A single start request with
//   one legal direction drives the turn command for TURN_MS millisecond ticks.
//   It then drives forward for CLEAR_MS ticks to clear the obstacle, and
//   finally reports completion with a one-cycle finish_turning pulse.
//   An abort request or reset cancels the manoeuvre at any point.
//
// Parameters:
//   TURN_MS   turn-phase length in ms ticks (1..65535)
//   CLEAR_MS  forward clearance-phase length in ms ticks (1..65535)
//
// Ports:
//   sys_clk         in   system clock, all logic on the rising edge
//   rst             in   synchronous reset, active-high
//   tick_ms         in   one-cycle pulse every millisecond
//   start           in   one-cycle turn request
//   dir_left        in   requested direction left (sampled with start)
//   dir_right       in   requested direction right (sampled with start)
//   abort           in   cancel any manoeuvre in progress
//   turn_left       out  drive command: turn left
//   turn_right      out  drive command: turn right
//   move_forward    out  drive command: forward during clearance
//   busy            out  high whenever the sequencer is not idle
//   finish_turning  out  one-cycle pulse on normal completion
//   dir_err         out  one-cycle pulse when a start has an illegal direction
// -----------------------------------------------------------------------------
module sauto_turn_ctrl #(
  parameter int TURN_MS  = 900,
  parameter int CLEAR_MS = 500
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic start,
  input  logic dir_left,
  input  logic dir_right,
  input  logic abort,
  output logic turn_left,
  output logic turn_right,
  output logic move_forward,
  output logic busy,
  output logic finish_turning,
  output logic dir_err
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TURN  = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Phase lengths narrowed to the counter width.
  localparam logic [15:0] L_TURN_LIM  = 16'(TURN_MS);
  localparam logic [15:0] L_CLEAR_LIM = 16'(CLEAR_MS);

  localparam logic [15:0] L_CNT_MAX = 16'hFFFF;

  // ---------------------------------------------------------------------------
  // Parity helpers. The FSM context (state + latched direction) and the tick
  // counter each carry a shadow parity bit so that a corrupted register is
  // detected and the drive commands are dropped instead of acting on it.
  // ---------------------------------------------------------------------------
  function automatic logic f_ctx_parity(input logic [1:0] state, input logic dir);
    return ^{state, dir};
  endfunction

  function automatic logic f_cnt_parity(input logic [15:0] cnt);
    return ^cnt;
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [15:0] r_cnt;
  logic        r_dir_left;     // latched direction: 1 = left, 0 = right
  logic        r_ctx_par;
  logic        r_cnt_par;
  logic        r_turn_left;
  logic        r_turn_right;
  logic        r_move_fwd;
  logic        r_busy;
  logic        r_finish;
  logic        r_dir_err;

  // ---------------------------------------------------------------------------
  // Combinational next-state signals
  // ---------------------------------------------------------------------------
  logic        w_start_legal;
  logic [15:0] w_cnt_inc;
  logic        w_ctx_ok;
  logic        w_cnt_ok;
  logic        w_cancel;
  logic [1:0]  w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic        w_dir_nxt;
  logic        w_dir_err_nxt;
  logic        w_turn_left_nxt;
  logic        w_turn_right_nxt;
  logic        w_move_fwd_nxt;
  logic        w_busy_nxt;
  logic        w_finish_nxt;

  // Start is only legal with exactly one direction requested.
  assign w_start_legal = dir_left ^ dir_right;

  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_inc = (r_cnt == L_CNT_MAX) ? L_CNT_MAX : (r_cnt + 16'd1);

  // Integrity checks of the stored context and counter.
  assign w_ctx_ok = (f_ctx_parity(r_state, r_dir_left) == r_ctx_par);
  assign w_cnt_ok = (f_cnt_parity(r_cnt) == r_cnt_par);

  // Abort and detected corruption both cancel silently: no DONE, no dir_err.
  assign w_cancel = abort | ~w_ctx_ok | ~w_cnt_ok;

  // Next-state, counter and direction-latch logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_dir_nxt     = r_dir_left;
    w_dir_err_nxt = 1'b0;

    if (w_cancel) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = 16'd0;
      w_dir_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Ticks are ignored here; a tick coinciding with the accepting
          // start is therefore never counted.
          w_cnt_nxt = 16'd0;
          if (start) begin
            if (w_start_legal) begin
              w_state_nxt = ST_TURN;
              w_dir_nxt   = dir_left;
            end else begin
              w_state_nxt   = ST_IDLE;
              w_dir_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        ST_TURN: begin
          if (tick_ms) begin
            if (w_cnt_inc == L_TURN_LIM) begin
              w_state_nxt = ST_CLEAR;
              w_cnt_nxt   = 16'd0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end

        ST_CLEAR: begin
          if (tick_ms) begin
            if (w_cnt_inc == L_CLEAR_LIM) begin
              w_state_nxt = ST_DONE;
              w_cnt_nxt   = 16'd0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end

        ST_DONE: begin
          // Single-cycle completion state; ticks and starts are ignored.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 16'd0;
          w_dir_nxt   = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the next state so that outputs are registered in step
  // with the state they describe.
  always_comb begin
    w_turn_left_nxt  = 1'b0;
    w_turn_right_nxt = 1'b0;
    w_move_fwd_nxt   = 1'b0;
    w_busy_nxt       = 1'b0;
    w_finish_nxt     = 1'b0;

    case (w_state_nxt)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      ST_TURN: begin
        w_busy_nxt       = 1'b1;
        w_turn_left_nxt  = w_dir_nxt;
        w_turn_right_nxt = ~w_dir_nxt;
      end
      ST_CLEAR: begin
        w_busy_nxt     = 1'b1;
        w_move_fwd_nxt = 1'b1;
      end
      ST_DONE: begin
        w_busy_nxt   = 1'b1;
        w_finish_nxt = 1'b1;
      end
      default: begin
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // State, counter, parity shadows and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 16'd0;
      r_dir_left   <= 1'b0;
      r_ctx_par    <= 1'b0;
      r_cnt_par    <= 1'b0;
      r_turn_left  <= 1'b0;
      r_turn_right <= 1'b0;
      r_move_fwd   <= 1'b0;
      r_busy       <= 1'b0;
      r_finish     <= 1'b0;
      r_dir_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dir_left   <= w_dir_nxt;
      r_ctx_par    <= f_ctx_parity(w_state_nxt, w_dir_nxt);
      r_cnt_par    <= f_cnt_parity(w_cnt_nxt);
      r_turn_left  <= w_turn_left_nxt;
      r_turn_right <= w_turn_right_nxt;
      r_move_fwd   <= w_move_fwd_nxt;
      r_busy       <= w_busy_nxt;
      r_finish     <= w_finish_nxt;
      r_dir_err    <= w_dir_err_nxt;
    end
  end

  assign turn_left      = r_turn_left;
  assign turn_right     = r_turn_right;
  assign move_forward   = r_move_fwd;
  assign busy           = r_busy;
  assign finish_turning = r_finish;
  assign dir_err        = r_dir_err;

endmodule
